// File: rtl/comp_iter_n.sv
// Iterative magnitude comparator: walks operand slices MSB-first, one CHUNK per clock,
// and stops at the first unequal slice. Signed mode maps operands to offset binary.
module comp_iter_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] slice_a, slice_b;

  // Flipping the sign bit turns a two's-complement compare into an unsigned one.
  assign msb_flip = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;
  assign slice_a  = CHUNK'(ra_q >> (idx_q * CHUNK));
  assign slice_b  = CHUNK'(rb_q >> (idx_q * CHUNK));

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ra_d    = a ^ msb_flip;
          rb_d    = b ^ msb_flip;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          state_d = StCmp;
        end else begin
          state_d = StIdle;
        end
      end
      StCmp: begin
        cnt_d = cnt_q + CW'(1);
        if (slice_a != slice_b) begin
          gt_d     = slice_a > slice_b;
          lt_d     = slice_a < slice_b;
          eq_d     = 1'b0;
          cycles_d = cnt_q + CW'(1);
          state_d  = StDone;
        end else if (idx_q == '0) begin
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          eq_d     = 1'b1;
          cycles_d = cnt_q + CW'(1);
          state_d  = StDone;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ra_q     <= '0;
      rb_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign busy   = (state_q == StCmp);
  assign done   = (state_q == StDone);
  assign gt     = gt_q;
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_comp_iter_n.sv
// Directed bench for comp_iter_n: default 16/4 instance plus 8/8 and 32/1 sweep instances.
module tb_comp_iter_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance, WIDTH=16 CHUNK=4
  logic        start, sm;
  logic [15:0] a, b;
  logic        busy, done, gt, eq, lt;
  logic [2:0]  cycles;

  comp_iter_n #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .cycles(cycles)
  );

  // WIDTH=8 CHUNK=8
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, gt8, eq8, lt8;
  logic [0:0] cycles8;

  comp_iter_n #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(1'b0), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8), .cycles(cycles8)
  );

  // WIDTH=32 CHUNK=1
  logic        start32;
  logic [31:0] a32, b32;
  logic        busy32, done32, gt32, eq32, lt32;
  logic [5:0]  cycles32;

  comp_iter_n #(.WIDTH(32), .CHUNK(1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(1'b0), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .gt(gt32), .eq(eq32), .lt(lt32), .cycles(cycles32)
  );

  // Launches one compare on the default instance from the current cycle and returns
  // when done is seen; lat counts clock edges from the start edge to the done cycle.
  task automatic run_cmp(input logic s, input logic [15:0] va, input logic [15:0] vb,
                         output int nbusy, output int lat);
    nbusy = 0;
    lat   = 0;
    sm    = s;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    sm    = ~s;
    for (int i = 1; i < 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if ({gt, eq, lt} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {gt, eq, lt});
    end
    checks++;
    if (cycles !== 3'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
  endtask

  task automatic test_equal();
    int nb, lat;
    run_cmp(1'b0, 16'h1234, 16'h1234, nb, lat);
    checks++;
    if (nb !== 4) begin errors++; $display("FAIL equal_busy got %0d want 4", nb); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL equal_latency got %0d want 5", lat); end
    checks++;
    if ({gt, eq, lt} !== 3'b010) begin
      errors++; $display("FAIL equal_flags got %b want 010", {gt, eq, lt});
    end
    checks++;
    if (cycles !== 3'd4) begin errors++; $display("FAIL equal_cycles got %0d want 4", cycles); end
    // done is a single-cycle pulse and results hold afterwards
    @(posedge clk); #1;
    checks++;
    if ({done, gt, eq, lt, cycles} !== {1'b0, 3'b010, 3'd4}) begin
      errors++; $display("FAIL equal_hold got %b want 0010100", {done, gt, eq, lt, cycles});
    end
  endtask

  task automatic test_msb_unsigned();
    int nb, lat;
    run_cmp(1'b0, 16'h8000, 16'h7FFF, nb, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL msb_latency got %0d want 2", lat); end
    checks++;
    if ({gt, eq, lt, cycles} !== {3'b100, 3'd1}) begin
      errors++; $display("FAIL msb_result got %b want 100001", {gt, eq, lt, cycles});
    end
  endtask

  task automatic test_signed();
    int nb, lat;
    run_cmp(1'b1, 16'h8000, 16'h7FFF, nb, lat);
    checks++;
    if ({gt, eq, lt, cycles} !== {3'b001, 3'd1}) begin
      errors++; $display("FAIL signed_min_max got %b want 001001", {gt, eq, lt, cycles});
    end
    run_cmp(1'b1, 16'hFFFF, 16'h0001, nb, lat);
    checks++;
    if ({gt, eq, lt} !== 3'b001) begin
      errors++; $display("FAIL signed_neg1_vs_1 got %b want 001", {gt, eq, lt});
    end
    run_cmp(1'b0, 16'hFFFF, 16'h0001, nb, lat);
    checks++;
    if ({gt, eq, lt, cycles} !== {3'b100, 3'd1}) begin
      errors++; $display("FAIL unsigned_ffff_vs_1 got %b want 100001", {gt, eq, lt, cycles});
    end
  endtask

  task automatic test_mid_slice();
    int lat = 0;
    sm    = 1'b0;
    a     = 16'h12E0;
    b     = 16'h12F0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    // restart attempt while busy must be ignored
    a     = 16'hFFFF;
    b     = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 3; i < 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL mid_latency got %0d want 4", lat); end
    checks++;
    if ({gt, eq, lt, cycles} !== {3'b001, 3'd3}) begin
      errors++; $display("FAIL mid_result got %b want 001011", {gt, eq, lt, cycles});
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    sm    = 1'b0;
    a     = 16'h1234;
    b     = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, gt, eq, lt, cycles} !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_async got %b want 00000000", {busy, done, gt, eq, lt, cycles});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int nb, lat;
    run_cmp(1'b0, 16'h8000, 16'h7FFF, nb, lat);
    checks++;
    if ({done, gt, eq, lt} !== 4'b1100) begin
      errors++; $display("FAIL b2b_first got %b want 1100", {done, gt, eq, lt});
    end
    // start driven during the DONE cycle
    sm    = 1'b0;
    a     = 16'h5A5A;
    b     = 16'h5A5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, gt, eq, lt, cycles} !== {1'b1, 3'b100, 3'd1}) begin
      errors++; $display("FAIL b2b_hold_on_start got %b want 1100001", {busy, gt, eq, lt, cycles});
    end
    lat = 0;
    for (int i = 1; i < 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
    checks++;
    if ({gt, eq, lt, cycles} !== {3'b010, 3'd4}) begin
      errors++; $display("FAIL b2b_second got %b want 010100", {gt, eq, lt, cycles});
    end
  endtask

  task automatic test_sweep();
    int lat = 0;
    a8     = 8'h05;
    b8     = 8'h09;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i < 20; i++) begin
      if (done8) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL w8_latency got %0d want 2", lat); end
    checks++;
    if ({gt8, eq8, lt8, cycles8} !== 4'b0011) begin
      errors++; $display("FAIL w8_result got %b want 0011", {gt8, eq8, lt8, cycles8});
    end

    lat     = 0;
    a32     = 32'hC0FFEE01;
    b32     = 32'hC0FFEE01;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int i = 1; i < 80; i++) begin
      if (done32) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL w32_latency got %0d want 33", lat); end
    checks++;
    if ({gt32, eq32, lt32, cycles32} !== {3'b010, 6'd32}) begin
      errors++; $display("FAIL w32_result got %b want 010100000", {gt32, eq32, lt32, cycles32});
    end
  endtask

  initial begin
    start   = 1'b0;
    sm      = 1'b0;
    a       = '0;
    b       = '0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    start32 = 1'b0;
    a32     = '0;
    b32     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_equal();
    test_msb_unsigned();
    test_signed();
    test_mid_slice();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
